// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: CPU (port 0) vs loader/debug (port 1).
// Optional perf counters under `DMEM_ARB_PERF_EN.
module dmem_arbiter #(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [2:0]    m0_mode,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ready,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [2:0]    m1_mode,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic          m1_lock,
  output logic          m1_ready,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_we,
  output logic [2:0]    mem_mode,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          cpu_stall,
  output logic [1:0]    owner
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]   perf_stall0,
  output logic [31:0]   perf_xfer1
`endif
);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] OWN0 = 2'b01;
  localparam logic [1:0] OWN1 = 2'b10;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [1:0] owner_q, owner_d;
  logic [7:0] hold_q, hold_d;
  logic       last_q, last_d;

  assign m0_ready  = (owner_q == OWN0) & m0_req;
  assign m1_ready  = (owner_q == OWN1) & m1_req;
  assign cpu_stall = m0_req & ~m0_ready;
  assign owner     = owner_q;
  assign m0_rdata  = mem_rdata;
  assign m1_rdata  = mem_rdata;

  always_comb begin
    mem_we    = 1'b0;
    mem_mode  = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (1'b1)
      m0_ready: begin
        mem_we    = m0_we;
        mem_mode  = m0_mode;
        mem_addr  = m0_addr;
        mem_wdata = m0_wdata;
      end
      m1_ready: begin
        mem_we    = m1_we;
        mem_mode  = m1_mode;
        mem_addr  = m1_addr;
        mem_wdata = m1_wdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    owner_d = owner_q;
    hold_d  = hold_q;
    last_d  = last_q;
    case (owner_q)
      IDLE: begin
        if (m0_req && m1_req)
          owner_d = last_q ? OWN0 : OWN1;
        else if (m0_req)
          owner_d = OWN0;
        else if (m1_req)
          owner_d = OWN1;
      end
      OWN0: begin
        if (!m0_req)
          owner_d = m1_req ? OWN1 : IDLE;
        else if (m1_req && hold_q == HOLD_LAST)
          owner_d = OWN1;
        else if (hold_q != HOLD_LAST)
          // saturates so a late port-1 request still sees the limit
          hold_d = hold_q + 8'd1;
      end
      OWN1: begin
        if (!m1_req && !m1_lock)
          owner_d = m0_req ? OWN0 : IDLE;
      end
      default: owner_d = IDLE;
    endcase
    if (owner_d != owner_q) begin
      hold_d = '0;
      if (owner_q == OWN0)
        last_d = 1'b0;
      else if (owner_q == OWN1)
        last_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q <= IDLE;
      hold_q  <= '0;
      last_q  <= 1'b1;
    end else begin
      owner_q <= owner_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
    end
  end

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] stall0_q, xfer1_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall0_q <= '0;
      xfer1_q  <= '0;
    end else begin
      if (cpu_stall && stall0_q != '1)
        stall0_q <= stall0_q + 32'd1;
      if (m1_ready && xfer1_q != '1)
        xfer1_q <= xfer1_q + 32'd1;
    end
  end

  assign perf_stall0 = stall0_q;
  assign perf_xfer1  = xfer1_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic
// checked against a transaction-level arbitration model.
module tb_dmem_arbiter;

  localparam int MH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we, m1_lock;
  logic [2:0]  m0_mode, m1_mode;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_ready, m1_ready, mem_we, cpu_stall;
  logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_mode;
  logic [1:0]  owner;
`ifdef DMEM_ARB_PERF_EN
  logic [31:0] perf_stall0, perf_xfer1;
`endif

  logic [31:0] dmem [0:63];
  logic [31:0] mmem [0:63];

  int n_chk = 0, n_pass = 0, n_fail = 0;
  int m_own, m_cnt, m_last, p_stall, p_x1;
  bit served0, served1;
  logic [31:0] last_rd0;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(32), .DW(32), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_mode(m0_mode),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_mode(m1_mode),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_lock(m1_lock),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .mem_we(mem_we), .mem_mode(mem_mode), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .cpu_stall(cpu_stall), .owner(owner)
`ifdef DMEM_ARB_PERF_EN
    , .perf_stall0(perf_stall0), .perf_xfer1(perf_xfer1)
`endif
  );

  assign mem_rdata = dmem[mem_addr[7:2]];

  always @(posedge clk)
    if (mem_we) dmem[mem_addr[7:2]] <= mem_wdata;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_own = 0; m_cnt = 0; m_last = 1; p_stall = 0; p_x1 = 0;
    served0 = 0; served1 = 0;
  endtask

  // Called at a negedge with inputs already applied.
  task automatic step();
    bit e0, e1, ewe;
    logic [31:0] ea, ed;
    logic [2:0] em;
    int nxt;
    #1;
    e0 = (m_own == 1) && m0_req;
    e1 = (m_own == 2) && m1_req;
    ewe = e0 ? m0_we : (e1 ? m1_we : 1'b0);
    ea = e0 ? m0_addr : (e1 ? m1_addr : 32'h0);
    ed = e0 ? m0_wdata : (e1 ? m1_wdata : 32'h0);
    em = e0 ? m0_mode : (e1 ? m1_mode : 3'h0);
    check("owner", owner, m_own);
    check("m0_ready", m0_ready, e0);
    check("m1_ready", m1_ready, e1);
    check("cpu_stall", cpu_stall, m0_req && !e0);
    check("mem_we", mem_we, ewe);
    check("mem_addr", mem_addr, ea);
    check("mem_wdata", mem_wdata, ed);
    check("mem_mode", mem_mode, em);
    if (e0) begin
      check("m0_rdata", m0_rdata, mmem[m0_addr[7:2]]);
      last_rd0 = m0_rdata;
    end
    if (e1) check("m1_rdata", m1_rdata, mmem[m1_addr[7:2]]);
`ifdef DMEM_ARB_PERF_EN
    check("perf_stall0", perf_stall0, p_stall);
    check("perf_xfer1", perf_xfer1, p_x1);
`endif
    @(posedge clk);
    if (ewe) mmem[ea[7:2]] = ed;
    if (m0_req && !e0) p_stall++;
    if (e1) p_x1++;
    nxt = m_own;
    case (m_own)
      0: begin
        if (m0_req && m1_req) nxt = (m_last == 1) ? 1 : 2;
        else if (m0_req) nxt = 1;
        else if (m1_req) nxt = 2;
      end
      1: begin
        if (!m0_req) nxt = m1_req ? 2 : 0;
        else begin
          m_cnt++;
          if (m1_req && m_cnt >= MH) nxt = 2;
        end
      end
      default: if (!m1_req && !m1_lock) nxt = m0_req ? 1 : 0;
    endcase
    if (nxt != m_own) begin
      if (m_own != 0) m_last = (m_own == 1) ? 0 : 1;
      m_cnt = 0;
      m_own = nxt;
    end
    served0 = e0;
    served1 = e1;
    @(negedge clk);
  endtask

  task automatic rand_inputs();
    if (!(m0_req && !served0)) begin
      m0_req = ($urandom % 4) != 0;
      m0_we = 1'($urandom);
      m0_mode = 3'($urandom);
      m0_addr = $urandom & 32'hFF;
      m0_wdata = $urandom;
    end
    if (!(m1_req && !served1)) begin
      m1_req = ($urandom % 3) == 0;
      m1_we = 1'($urandom);
      m1_mode = 3'($urandom);
      m1_addr = $urandom & 32'hFF;
      m1_wdata = $urandom;
    end
    m1_lock = ($urandom % 6) == 0;
  endtask

  initial begin
    bit got;
    for (int i = 0; i < 64; i++) begin
      dmem[i] = 32'hA000_0000 + i;
      mmem[i] = 32'hA000_0000 + i;
    end
    rst = 1'b0;
    m0_req = 1; m0_we = 1; m0_mode = 3'd2;
    m0_addr = 32'h10; m0_wdata = 32'hDEADBEEF;
    m1_req = 1; m1_we = 1; m1_mode = 3'd2;
    m1_addr = 32'h24; m1_wdata = 32'h1234;
    m1_lock = 0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("rst_owner", owner, 2'b00);
    check("rst_m0_ready", m0_ready, 1'b0);
    check("rst_m1_ready", m1_ready, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    @(negedge clk);

    // single CPU store
    rst = 1'b1;
    m1_req = 0;
    step();
    step();
    check("st_data", mmem[4], 32'hDEADBEEF);
    m0_req = 0;
    step();

    // both requesting: hold limit then handover
    m0_req = 1; m0_we = 0; m0_addr = 32'h40;
    m1_req = 1; m1_we = 0; m1_addr = 32'h44;
    repeat (10) step();
    m1_req = 0;
    repeat (3) step();
    m0_req = 0;
    step();

    // burst lock: port 1 keeps ownership
    m1_req = 1; m1_lock = 1;
    repeat (2) step();
    m0_req = 1;
    for (int i = 0; i < 6; i++) begin
      m1_req = (i % 2) == 0;
      step();
    end
    m1_req = 0; m1_lock = 0;
    repeat (2) step();
    m0_req = 0;
    step();

    // port 1 writes, port 0 reads back
    m1_req = 1; m1_we = 1; m1_addr = 32'h20; m1_wdata = 32'h55;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      step();
      got = served1;
    end
    check("p1_wr_done", got, 1'b1);
    m1_req = 0;
    m0_req = 1; m0_we = 0; m0_addr = 32'h20;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      step();
      got = served0;
    end
    check("p0_rd_done", got, 1'b1);
    check("p0_rd_val", last_rd0, 32'h55);
    m0_req = 0;
    step();

    // reset in the middle of a locked port-1 write burst
    m1_req = 1; m1_we = 1; m1_lock = 1;
    m1_addr = 32'h30; m1_wdata = 32'hCAFE;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      step();
      got = served1;
    end
    check("burst_start", got, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("arst_owner", owner, 2'b00);
    check("arst_mem_we", mem_we, 1'b0);
    check("arst_m1_ready", m1_ready, 1'b0);
    @(negedge clk);
    model_reset();
    rst = 1'b1;
    m1_lock = 0; m1_we = 0;
    m0_req = 1; m0_we = 0; m0_addr = 32'h8;
    step();
    step();
    m0_req = 0; m1_req = 0;
    step();

    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
